seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 177 +++++++++++++++++
 tb/tb_seq_alu.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus a WIDTH-cycle restoring divider.
// Define SEQ_ALU_RNG_EN to compile in the xorshift RNG op (op 8).
module seq_alu #(
   parameter int WIDTH = 16,
   parameter int IMM_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [IMM_W-1:0] imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             sign,
   output logic             div0
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   state_t           st_q, st_d;
   logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d, rem_q, rem_d;
   logic [WIDTH-1:0] res_q, res_d, nres, alu;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             mod_q, mod_d;
   logic             zero_q, zero_d, sign_q, sign_d;
   logic             div0_q, div0_d, ndiv0, ld;
   logic [WIDTH-1:0] sx, zx, step_rem, step_quo;
   logic [WIDTH:0]   trial, diff;

   assign sx = WIDTH'($signed(imm));
   assign zx = WIDTH'(imm);

`ifdef SEQ_ALU_RNG_EN
   logic [WIDTH-1:0] s_q, r1, r2, r3, rng_n;

   assign r1    = s_q + 1'b1;
   assign r2    = r1 ^ (r1 << 7);
   assign r3    = r2 ^ (r2 >> 9);
   assign rng_n = r3 ^ (r3 << 8);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         s_q <= '0;
      else if (in_valid && in_ready && op == 4'd8)
         s_q <= rng_n;
   end
`endif

   always_comb begin
      alu = '0;
      case (op)
         4'd0:    alu = a + b + sx;
         4'd1:    alu = a - b - sx;
         4'd2:    alu = a & (b | zx);
         4'd3:    alu = a | b | zx;
         4'd4:    alu = a * (b + sx);
         4'd6:    alu = a ^ (b | zx);
         default: alu = '0;
      endcase
   end

   // One restoring step: shift the next dividend bit into the partial remainder.
   assign trial    = {rem_q, quo_q[WIDTH-1]};
   assign diff     = trial - {1'b0, dvs_q};
   assign step_rem = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
   assign step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

   always_comb begin
      st_d   = st_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      rem_d  = rem_q;
      cnt_d  = cnt_q;
      mod_d  = mod_q;
      res_d  = res_q;
      zero_d = zero_q;
      sign_d = sign_q;
      div0_d = div0_q;
      nres   = '0;
      ndiv0  = 1'b0;
      unique case (st_q)
         IDLE: begin
            if (in_valid) begin
               st_d = DONE;
               nres = alu;
               if (op == 4'd5 || op == 4'd7) begin
                  if (b == '0) begin
                     nres  = (op == 4'd7) ? '1 : a;
                     ndiv0 = 1'b1;
                  end else begin
                     st_d  = DIV;
                     quo_d = a;
                     dvs_d = b;
                     rem_d = '0;
                     cnt_d = '0;
                     mod_d = (op == 4'd5);
                  end
               end
`ifdef SEQ_ALU_RNG_EN
               if (op == 4'd8) begin
                  nres = rng_n;
                  if (a != '0) begin
                     st_d  = DIV;
                     quo_d = rng_n;
                     dvs_d = a;
                     rem_d = '0;
                     cnt_d = '0;
                     mod_d = 1'b1;
                  end
               end
`endif
            end
         end
         DIV: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 1'b1;
            nres  = mod_q ? step_rem : step_quo;
            if (cnt_q == CW'(WIDTH - 1))
               st_d = DONE;
         end
         DONE: begin
            if (out_ready)
               st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
      ld = (st_q != DONE) && (st_d == DONE);
      if (ld) begin
         res_d  = nres;
         zero_d = (nres == '0);
         sign_d = nres[WIDTH-1];
         div0_d = ndiv0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= IDLE;
         quo_q  <= '0;
         dvs_q  <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         mod_q  <= 1'b0;
         res_q  <= '0;
         zero_q <= 1'b0;
         sign_q <= 1'b0;
         div0_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         rem_q  <= rem_d;
         cnt_q  <= cnt_d;
         mod_q  <= mod_d;
         res_q  <= res_d;
         zero_q <= zero_d;
         sign_q <= sign_d;
         div0_q <= div0_d;
      end
   end

   assign in_ready  = (st_q == IDLE);
   assign out_valid = (st_q == DONE);
   assign result    = res_q;
   assign zero      = zero_q;
   assign sign      = sign_q;
   assign div0      = div0_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16, IMM_W=5).
// Covers both builds: op 8 is checked as RNG or as an illegal op.
module tb_seq_alu;

   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  op;
   logic [15:0] a, b, result;
   logic [4:0]  imm;
   logic        zero, sign, div0;
   int          total, bad;

   seq_alu #(.WIDTH(16), .IMM_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .sign(sign), .div0(div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic [3:0] o,
                      input logic [15:0] av, input logic [15:0] bv,
                      input logic [4:0] iv, input logic [15:0] er,
                      input logic ez, input logic es, input logic ed,
                      input int elat);
      int lat;
      logic ok;
      logic [15:0] prev;
      @(negedge clk);
      chk({tag, "/rdy"}, in_ready, 1'b1);
      prev = result;
      op = o; a = av; b = bv; imm = iv; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF; imm = 5'h15; op = 4'd0;
      lat = 1;
      ok = 1'b1;
      while (!out_valid && lat < 100) begin
         if (in_ready !== 1'b0 || result !== prev) ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "/lat"}, lat, elat);
      chk({tag, "/busy"}, ok, 1'b1);
      chk({tag, "/res"}, result, er);
      chk({tag, "/zero"}, zero, ez);
      chk({tag, "/sign"}, sign, es);
      chk({tag, "/div0"}, div0, ed);
      if (out_ready) begin
         @(posedge clk); #1;
         chk({tag, "/idle"}, {in_ready, out_valid}, 2'b10);
      end
   endtask

   initial begin
      int ok;
      logic [15:0] hold;
      total = 0; bad = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; a = '0; b = '0; imm = '0;
      #12;
      chk("rst/outs", {in_ready, out_valid, zero, sign, div0}, 5'b10000);
      chk("rst/res", result, 16'h0);
      @(posedge clk); #2;
      rst_n = 1'b1;

`ifdef SEQ_ALU_RNG_EN
      run("rng1", 4'd8, 16'd0, 16'd0, 5'd0, 16'h8181, 0, 1, 0, 1);
`else
      run("op8ill", 4'd8, 16'd0, 16'd0, 5'd0, 16'h0, 1, 0, 0, 1);
`endif
      run("add", 4'd0, 16'd5, 16'd3, 5'b11111, 16'h0007, 0, 0, 0, 1);
      run("sub", 4'd1, 16'd3, 16'd5, 5'd0, 16'hFFFE, 0, 1, 0, 1);
      run("and", 4'd2, 16'h00F0, 16'h0F00, 5'd0, 16'h0, 1, 0, 0, 1);
      run("or", 4'd3, 16'h1200, 16'h0034, 5'b10001, 16'h1235, 0, 0, 0, 1);
      run("mul", 4'd4, 16'd3, 16'd5, 5'b11110, 16'd9, 0, 0, 0, 1);
      run("mulw", 4'd4, 16'h1234, 16'h0100, 5'd0, 16'h3400, 0, 0, 0, 1);
      run("xor", 4'd6, 16'hFFFF, 16'h00F0, 5'h0F, 16'hFF00, 0, 1, 0, 1);
      run("div", 4'd7, 16'd100, 16'd7, 5'd0, 16'd14, 0, 0, 0, 17);
      run("mod", 4'd5, 16'd100, 16'd7, 5'd0, 16'd2, 0, 0, 0, 17);
      run("div0", 4'd7, 16'd9, 16'd0, 5'd0, 16'hFFFF, 0, 1, 1, 1);
      run("mod0", 4'd5, 16'd9, 16'd0, 5'd0, 16'd9, 0, 0, 1, 1);
      run("addclr", 4'd0, 16'd1, 16'd1, 5'd0, 16'd2, 0, 0, 0, 1);
      run("divmax", 4'd7, 16'hFFFF, 16'd1, 5'd0, 16'hFFFF, 0, 1, 0, 17);
      run("modz", 4'd5, 16'hFFFF, 16'h00FF, 5'd0, 16'h0, 1, 0, 0, 17);
      run("ill", 4'd12, 16'd5, 16'd5, 5'd3, 16'h0, 1, 0, 0, 1);
`ifdef SEQ_ALU_RNG_EN
      run("rng2", 4'd8, 16'd0, 16'd0, 5'd0, 16'hE2A2, 0, 1, 0, 1);
      run("rngmod", 4'd8, 16'd10, 16'd0, 5'd0, 16'd8, 0, 0, 0, 17);
`endif

      out_ready = 1'b0;
      run("stall", 4'd1, 16'h0001, 16'h0002, 5'd0, 16'hFFFF, 0, 1, 0, 1);
      hold = result;
      ok = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (result !== hold || out_valid !== 1'b1 || in_ready !== 1'b0 ||
             {zero, sign, div0} !== 3'b010) ok = 0;
      end
      chk("stall/hold", ok, 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall/rel", {in_ready, out_valid}, 2'b10);

      @(negedge clk);
      op = 4'd7; a = 16'd1000; b = 16'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rstdiv/outs", {in_ready, out_valid, zero, sign, div0}, 5'b10000);
      chk("rstdiv/res", result, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || result !== 16'h0) ok = 0;
      end
      chk("rstdiv/stale", ok, 1);
`ifdef SEQ_ALU_RNG_EN
      run("rngrst", 4'd8, 16'd0, 16'd0, 5'd0, 16'h8181, 0, 1, 0, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
